// File: rtl/spiker_reader_if.sv
// Register-file / core / writer side signals of the spiker input reader.
// The slave modport faces the reader; the master modport faces whoever drives it.
interface spiker_reader_if #(
   parameter int WIDTH    = 32,
   parameter int N_SPIKES = 784,
   parameter int IDX_W    = 5
);
   logic [WIDTH-1:0]    word_i;
   logic [IDX_W-1:0]    word_idx_i;
   logic                word_we_i;
   logic                clear_i;
   logic                start_i;
   logic                abort_i;
   logic                core_ready_i;
   logic                result_valid_i;
   logic                writer_ready_i;
   logic [N_SPIKES-1:0] spikes_o;
   logic                valid_o;
   logic                sample_o;
   logic                busy_o;
   logic                done_o;
   logic                err_o;

   modport slave (
      input  word_i, word_idx_i, word_we_i, clear_i, start_i, abort_i,
             core_ready_i, result_valid_i, writer_ready_i,
      output spikes_o, valid_o, sample_o, busy_o, done_o, err_o
   );

   modport master (
      output word_i, word_idx_i, word_we_i, clear_i, start_i, abort_i,
             core_ready_i, result_valid_i, writer_ready_i,
      input  spikes_o, valid_o, sample_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/spiker_reader.sv
// Input stage of the spiker adapter: buffers the spike frame written by software
// and steps the core through N_STEPS timesteps, pulsing sample_o after each drain.
module spiker_reader #(
   parameter int WIDTH    = 32,
   parameter int N_SPIKES = 784,
   parameter int N_WORDS  = 25,
   parameter int N_STEPS  = 15,
   parameter int IDX_W    = 5
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   spiker_reader_if.slave bus
);
   localparam int CNT_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, WAIT_DRAIN, STEP} state_e;

   state_e              state_q;
   logic [CNT_W-1:0]    step_cnt_q;
   logic                seen_low_q;
   logic                valid_q, sample_q, done_q, err_q;
   logic [N_SPIKES-1:0] buf_w;

   logic idle, idx_ok, wr_en, clr_en, err_set, start_ok, last_step;

   assign idle      = (state_q == IDLE);
   assign idx_ok    = {1'b0, bus.word_idx_i} < (IDX_W+1)'(N_WORDS);
   assign clr_en    = idle && bus.clear_i;
   assign wr_en     = idle && bus.word_we_i && idx_ok && !bus.clear_i;
   assign start_ok  = idle && bus.start_i && !bus.abort_i;
   assign last_step = (step_cnt_q == CNT_W'(N_STEPS-1));
   assign err_set   = (bus.word_we_i && (!idle || !idx_ok))
                    || (!idle && (bus.clear_i || bus.start_i));

   // Each word holds only the bits that land below N_SPIKES, so the tail of the
   // last word is never stored.
   for (genvar w = 0; w < N_WORDS; w++) begin : g_word
      localparam int LO   = w * WIDTH;
      localparam int BITS = (N_SPIKES - LO < WIDTH) ? (N_SPIKES - LO) : WIDTH;
      logic [BITS-1:0] word_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)
            word_q <= '0;
         else if (clr_en)
            word_q <= '0;
         else if (wr_en && bus.word_idx_i == IDX_W'(w))
            word_q <= bus.word_i[BITS-1:0];
      end

      assign buf_w[LO +: BITS] = word_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         step_cnt_q <= '0;
         seen_low_q <= 1'b0;
         valid_q    <= 1'b0;
         sample_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         sample_q <= 1'b0;
         done_q   <= 1'b0;
         if (start_ok) err_q <= 1'b0;
         if (err_set)  err_q <= 1'b1;

         if (!idle && bus.abort_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (start_ok) begin
                  state_q    <= ISSUE;
                  step_cnt_q <= '0;
                  valid_q    <= 1'b1;
               end
               ISSUE: if (bus.core_ready_i) begin
                  state_q <= WAIT_RES;
                  valid_q <= 1'b0;
               end
               WAIT_RES: if (bus.result_valid_i) begin
                  state_q    <= WAIT_DRAIN;
                  seen_low_q <= 1'b0;
               end
               // The writer's ready is still high from before the result; only a
               // 1 that follows a 0 means the pipeline has actually drained.
               WAIT_DRAIN: begin
                  if (!bus.writer_ready_i)
                     seen_low_q <= 1'b1;
                  else if (seen_low_q) begin
                     state_q  <= STEP;
                     sample_q <= 1'b1;
                     done_q   <= last_step;
                  end
               end
               STEP: begin
                  if (last_step)
                     state_q <= IDLE;
                  else begin
                     step_cnt_q <= step_cnt_q + 1'b1;
                     state_q    <= ISSUE;
                     valid_q    <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.spikes_o = buf_w;
   assign bus.valid_o  = valid_q;
   assign bus.sample_o = sample_q;
   assign bus.busy_o   = !idle;
   assign bus.done_o   = done_q;
   assign bus.err_o    = err_q;
endmodule

// File: tb/tb_spiker_reader.sv
// Directed bench for spiker_reader: buffer load, error flagging, full inference,
// core back-pressure, drain qualification, abort and reset.
module tb_spiker_reader;
   localparam int WIDTH = 32, N_SPIKES = 784, N_WORDS = 25, N_STEPS = 15, IDX_W = 5;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   int   nchk = 0, nerr = 0;
   int   cyc = 0, sample_cnt = 0, done_cnt = 0;
   int   sample_cyc[$];
   logic [N_SPIKES-1:0] snap;

   always #5 clk_i = ~clk_i;

   spiker_reader_if #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES), .IDX_W(IDX_W)) bus ();

   spiker_reader #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES), .N_WORDS(N_WORDS),
                   .N_STEPS(N_STEPS), .IDX_W(IDX_W))
      dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus.slave));

   task automatic chk(input string tag, input logic [N_SPIKES-1:0] obs,
                      input logic [N_SPIKES-1:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; outputs are observed on the falling edge.
   task automatic tick();
      @(negedge clk_i);
      cyc++;
      if (bus.sample_o === 1'b1) begin
         sample_cnt++;
         sample_cyc.push_back(cyc);
      end
      if (bus.done_o === 1'b1) done_cnt++;
   endtask

   task automatic wr(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] d);
      bus.word_i = d; bus.word_idx_i = idx; bus.word_we_i = 1'b1;
      tick();
      bus.word_we_i = 1'b0;
   endtask

   // Entered while the reader sits in ISSUE; leaves it in the next ISSUE or IDLE.
   task automatic do_step(input int hold, input bit last, input bit stall_drain);
      snap = bus.spikes_o;
      for (int i = 0; i < hold; i++) begin
         bus.core_ready_i = 1'b0;
         tick();
         chk("bp_valid", bus.valid_o, 1);
         chk("bp_spikes", bus.spikes_o, snap);
      end
      bus.core_ready_i = 1'b1;
      tick();
      chk("acc_valid", bus.valid_o, 0);
      bus.core_ready_i = 1'b0; bus.result_valid_i = 1'b1;
      tick();
      chk("res_sample", bus.sample_o, 0);
      bus.result_valid_i = 1'b0;
      if (stall_drain) begin
         bus.writer_ready_i = 1'b1;
         tick();
         chk("stale_ready", bus.sample_o, 0);
      end
      bus.writer_ready_i = 1'b0;
      tick();
      chk("drain_sample", bus.sample_o, 0);
      bus.writer_ready_i = 1'b1;
      tick();
      chk("step_sample", bus.sample_o, 1);
      chk("step_done", bus.done_o, last);
      bus.writer_ready_i = 1'b0;
      tick();
      chk("post_sample", bus.sample_o, 0);
      chk("post_valid", bus.valid_o, !last);
      chk("post_busy", bus.busy_o, !last);
   endtask

   initial begin
      bus.word_i = '0; bus.word_idx_i = '0; bus.word_we_i = 1'b0;
      bus.clear_i = 1'b0; bus.start_i = 1'b0; bus.abort_i = 1'b0;
      bus.core_ready_i = 1'b0; bus.result_valid_i = 1'b0; bus.writer_ready_i = 1'b0;
      tick(); tick();
      chk("rst_spikes", bus.spikes_o, 0);
      chk("rst_outs", {bus.valid_o, bus.sample_o, bus.busy_o, bus.done_o, bus.err_o}, 0);
      rst_ni = 1'b1;
      tick();

      // Buffer load, last word truncated to 16 bits
      wr(5'd0, 32'hDEADBEEF);
      wr(5'd24, 32'hFFFFFFFF);
      tick();
      chk("w0", bus.spikes_o[31:0], 32'hDEADBEEF);
      chk("w24", bus.spikes_o[783:768], 16'hFFFF);
      chk("w23", bus.spikes_o[767:736], 0);
      chk("load_err", bus.err_o, 0);

      wr(5'd25, 32'h55555555);
      chk("oob_err", bus.err_o, 1);
      chk("oob_w0", bus.spikes_o[31:0], 32'hDEADBEEF);
      chk("oob_w24", bus.spikes_o[783:768], 16'hFFFF);

      // Full run with one back-pressured issue
      sample_cnt = 0; done_cnt = 0; sample_cyc.delete();
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      chk("start_err", bus.err_o, 0);
      chk("start_busy", bus.busy_o, 1);
      chk("start_valid", bus.valid_o, 1);
      do_step(10, 1'b0, 1'b0);
      for (int s = 1; s < N_STEPS; s++) do_step(0, s == N_STEPS-1, 1'b0);
      chk("run1_samples", sample_cnt, 15);
      chk("run1_done", done_cnt, 1);
      for (int i = 2; i < sample_cyc.size(); i++)
         chk("run1_gap", sample_cyc[i] - sample_cyc[i-1], 5);

      // Illegal write/start while issuing, then abort at step 7
      sample_cnt = 0; done_cnt = 0;
      bus.start_i = 1'b1;
      tick();
      bus.word_i = 32'h12345678; bus.word_idx_i = 5'd0; bus.word_we_i = 1'b1;
      tick();
      bus.word_we_i = 1'b0; bus.start_i = 1'b0;
      chk("iss_err", bus.err_o, 1);
      chk("iss_w0", bus.spikes_o[31:0], 32'hDEADBEEF);
      chk("iss_valid", bus.valid_o, 1);
      for (int s = 0; s < 7; s++) do_step(0, 1'b0, 1'b0);
      bus.core_ready_i = 1'b1;
      tick();
      bus.core_ready_i = 1'b0; bus.result_valid_i = 1'b1;
      tick();
      bus.result_valid_i = 1'b0; bus.abort_i = 1'b1;
      tick();
      bus.abort_i = 1'b0;
      chk("abort_busy", bus.busy_o, 0);
      chk("abort_valid", bus.valid_o, 0);
      bus.writer_ready_i = 1'b1;
      tick(); tick();
      bus.writer_ready_i = 1'b0;
      chk("abort_samples", sample_cnt, 7);
      chk("abort_done", done_cnt, 0);

      // Restart counts from step 0; one step sees a stale high ready
      sample_cnt = 0; done_cnt = 0;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      chk("restart_err", bus.err_o, 0);
      for (int s = 0; s < N_STEPS; s++) do_step(0, s == N_STEPS-1, s == 3);
      chk("run2_samples", sample_cnt, 15);
      chk("run2_done", done_cnt, 1);

      // abort+start in IDLE: start ignored without error
      bus.start_i = 1'b1; bus.abort_i = 1'b1;
      tick();
      bus.start_i = 1'b0; bus.abort_i = 1'b0;
      chk("ab_st_busy", bus.busy_o, 0);
      chk("ab_st_err", bus.err_o, 0);

      // clear beats a simultaneous write
      bus.clear_i = 1'b1;
      wr(5'd1, 32'hCAFEF00D);
      bus.clear_i = 1'b0;
      chk("clear_all", bus.spikes_o, 0);

      // Asynchronous reset mid-inference
      wr(5'd3, 32'hA5A5A5A5);
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_busy", bus.busy_o, 0);
      chk("arst_valid", bus.valid_o, 0);
      chk("arst_spikes", bus.spikes_o, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
